wta_bus_mux_reg: RTL

- Parametrised, registered successor to the processor's write-to-bus (WTA) source selector.
- Selects one of NUM_SRC register sources onto the shared datapath bus and zero-extends narrow sources.
- Registers the result behind a valid/ready handshake, with selectable hold/clear mode and an illegal-select flag.
- Sits between the register file / special registers (N, M, P, ROW, COL, CURR, SUM, STA..STC, A, B, R) and the bus consumers; driven by the control unit.

---
 rtl/wta_pkg.sv | 27 ++
 rtl/wta_out_stage.sv | 55 +++++
 rtl/wta_bus_mux_reg.sv | 60 ++++++
 3 files changed

// File: rtl/wta_pkg.sv
// Shared constants for the write-to-bus source selector: select codes and
// default widths/masks used by wta_bus_mux_reg and its output stage.
package wta_pkg;

  localparam int NUM_SRC_DEFAULT = 16;
  localparam int DATA_W_DEFAULT  = 16;
  localparam logic [15:0] NARROW_MASK_DEFAULT = 16'h00EE;

  typedef enum logic [3:0] {
    SEL_NONE = 4'd0,
    SEL_N    = 4'd1,
    SEL_M    = 4'd2,
    SEL_P    = 4'd3,
    SEL_R1   = 4'd4,
    SEL_ROW  = 4'd5,
    SEL_COL  = 4'd6,
    SEL_CURR = 4'd7,
    SEL_SUM  = 4'd8,
    SEL_STA  = 4'd9,
    SEL_STB  = 4'd10,
    SEL_STC  = 4'd11,
    SEL_A    = 4'd12,
    SEL_B    = 4'd13,
    SEL_R    = 4'd14
  } wta_sel_e;

endpackage

// File: rtl/wta_out_stage.sv
// One-entry registered output stage with valid/ready, hold-or-clear idle
// behaviour, an illegal-select pulse and a wrapping completed-transfer count.
module wta_out_stage
  import wta_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter bit HOLD_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              in_ready,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              sel_err,
  output logic [15:0]       xfer_cnt
);

  logic accept;
  logic complete;

  assign in_ready = !bus_valid || bus_ready;
  assign accept   = in_valid && in_ready;
  assign complete = bus_valid && bus_ready;

  // A completion and a new accept in the same cycle keep bus_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_data  <= '0;
      bus_valid <= 1'b0;
      sel_err   <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      sel_err <= accept && in_err;
      if (complete) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (accept) begin
        bus_data  <= in_data;
        bus_valid <= 1'b1;
      end else if (complete) begin
        bus_valid <= 1'b0;
        if (HOLD_MODE == 1'b0) begin
          bus_data <= '0;
        end
      end else if (!bus_valid && (HOLD_MODE == 1'b0)) begin
        bus_data <= '0;
      end
    end
  end

endmodule

// File: rtl/wta_bus_mux_reg.sv
// Registered write-to-bus selector: picks one source slot, zero-extends narrow
// sources, and hands the word to the output stage behind valid/ready.
module wta_bus_mux_reg
  import wta_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter logic [NUM_SRC-1:0] NARROW_MASK = NUM_SRC'(NARROW_MASK_DEFAULT),
  parameter bit HOLD_MODE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      req_valid,
  input  logic [SEL_W-1:0]          req_sel,
  output logic                      req_ready,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic                      sel_err,
  output logic [15:0]               xfer_cnt
);

  logic [DATA_W-1:0] sel_data;
  logic              sel_legal;

  // Slot 0 and codes beyond the last slot match nothing, leaving data at 0.
  always_comb begin
    sel_data  = '0;
    sel_legal = 1'b0;
    for (int i = int'(SEL_NONE) + 1; i < NUM_SRC; i++) begin
      if (req_sel == SEL_W'(i)) begin
        sel_legal = 1'b1;
        sel_data  = src_data[i*DATA_W +: DATA_W];
        if (NARROW_MASK[i]) begin
          sel_data[DATA_W-1:8] = '0;
        end
      end
    end
  end

  wta_out_stage #(
    .DATA_W    (DATA_W),
    .HOLD_MODE (HOLD_MODE)
  ) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (req_valid),
    .in_data   (sel_data),
    .in_err    (!sel_legal),
    .in_ready  (req_ready),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .sel_err   (sel_err),
    .xfer_cnt  (xfer_cnt)
  );

endmodule
